digclk_seg_scan: RTL and testbench

//  Downstream display stage of the digital clock timer. Captures hh/mm/ss binary time

---
 rtl/digclk_seg_scan_if.sv | 14 +
 rtl/digclk_seg_scan.sv | 141 ++++++++++++++
 tb/tb_digclk_seg_scan.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/digclk_seg_scan_if.sv
// Display bus for the clock display stage: timer-side snapshot inputs and pin-level display outputs.
interface digclk_seg_scan_if;
  logic       upd;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       err;

  modport master (output upd, hh, mm, ss, input  seg, dp, an, err);
  modport slave  (input  upd, hh, mm, ss, output seg, dp, an, err);
endinterface

// File: rtl/digclk_seg_scan.sv
// 6-digit HH.MM.SS multiplexed 7-segment driver with anti-ghost blanking.
// Optional macro COLON_BLINK_EN: separator dots follow the snapshot seconds parity.
module digclk_seg_scan #(
  parameter int SCAN_DIV       = 16667,
  parameter int BLANK_CYC      = 4,
  parameter int LZ_BLANK       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  digclk_seg_scan_if.slave   bus
);

  localparam int            PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_CMP = PW'(BLANK_CYC);
  localparam logic [2:0]    IDX_MAX   = 3'd5;
  localparam logic [6:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_OFF    = (SEG_ACTIVE_LOW != 0);
  localparam logic [5:0]    AN_OFF    = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
  localparam logic [6:0]    CODE_DASH = 7'h40;
  localparam logic [6:0]    CODE_BLNK = 7'h00;

  logic [4:0]    hh_q, hh_d;
  logic [5:0]    mm_q, mm_d;
  logic [5:0]    ss_q, ss_d;
  logic          err_q, err_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [5:0] field;
  logic [5:0] digit;
  logic [6:0] code;
  logic       dp_act;
  logic       dp_sep;
  logic       lit;

  function automatic logic [6:0] seg_code(input logic [5:0] d);
    case (d)
      6'd0:    seg_code = 7'h3F;
      6'd1:    seg_code = 7'h06;
      6'd2:    seg_code = 7'h5B;
      6'd3:    seg_code = 7'h4F;
      6'd4:    seg_code = 7'h66;
      6'd5:    seg_code = 7'h6D;
      6'd6:    seg_code = 7'h7D;
      6'd7:    seg_code = 7'h07;
      6'd8:    seg_code = 7'h7F;
      6'd9:    seg_code = 7'h6F;
      default: seg_code = CODE_BLNK;
    endcase
  endfunction

  always_comb begin
    hh_d  = hh_q;
    mm_d  = mm_q;
    ss_d  = ss_q;
    err_d = err_q;
    if (bus.upd) begin
      hh_d  = bus.hh;
      mm_d  = bus.mm;
      ss_d  = bus.ss;
      err_d = (bus.hh > 5'd23) || (bus.mm > 6'd59) || (bus.ss > 6'd59);
    end

    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PRE_MAX) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Even slots show units, odd slots tens; slot pairs select ss, mm, hh.
  always_comb begin
    if (idx_q[2])      field = {1'b0, hh_q};
    else if (idx_q[1]) field = mm_q;
    else               field = ss_q;
    digit = idx_q[0] ? (field / 6'd10) : (field % 6'd10);

`ifdef COLON_BLINK_EN
    dp_sep = ~ss_q[0];
`else
    dp_sep = 1'b1;
`endif

    lit = (pre_q >= BLANK_CMP);
    if (err_q) begin
      code   = CODE_DASH;
      dp_act = 1'b0;
    end else begin
      code   = seg_code(digit);
      if ((LZ_BLANK != 0) && (idx_q == IDX_MAX) && (hh_q < 5'd10))
        code = CODE_BLNK;
      dp_act = ((idx_q == 3'd2) || (idx_q == 3'd4)) && dp_sep;
    end

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (lit) begin
      an_d  = (AN_ACTIVE_LOW != 0)  ? ~(6'd1 << idx_q) : (6'd1 << idx_q);
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~code : code;
      dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_act : dp_act;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hh_q  <= '0;
      mm_q  <= '0;
      ss_q  <= '0;
      err_q <= 1'b0;
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
    end else begin
      hh_q  <= hh_d;
      mm_q  <= mm_d;
      ss_q  <= ss_d;
      err_q <= err_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_digclk_seg_scan.sv
// Randomized and directed checks of the HH.MM.SS scan driver against a time-based display model.
module tb_digclk_seg_scan;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;

  logic clk;
  logic rst_n;

  digclk_seg_scan_if bus ();

  digclk_seg_scan #(
    .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .LZ_BLANK(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int k;
  int m_hh, m_mm, m_ss;
  bit m_err;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at t=%0t cyc=%0d: got %0h want %0h", tag, $time, k, obs, exp_v);
    end
  endtask

  // Display as a function of elapsed cycles p since release and the held time.
  task automatic model_out(input int p, output logic [5:0] an_e,
                           output logic [6:0] seg_e, output logic dp_e);
    int pre, idx;
    int d [6];
    logic [6:0] code;
    logic dpl;
    bit blink;
    pre = p % SCAN_DIV;
    idx = (p / SCAN_DIV) % 6;
    d = '{m_ss % 10, m_ss / 10, m_mm % 10, m_mm / 10, m_hh % 10, m_hh / 10};
    an_e  = 6'h3F;
    seg_e = 7'h7F;
    dp_e  = 1'b1;
    if (pre >= BLANK_CYC) begin
      an_e = ~(6'd1 << idx);
      if (m_err) begin
        code = 7'h40;
        dpl  = 1'b0;
      end else begin
        code = (idx == 5 && m_hh < 10) ? 7'h00 : seg_tab[d[idx]];
        blink = 1'b1;
`ifdef COLON_BLINK_EN
        blink = (m_ss % 2 == 0);
`endif
        dpl = (idx == 2 || idx == 4) && blink;
      end
      seg_e = ~code;
      dp_e  = ~dpl;
    end
  endtask

  task automatic step(input bit u, input int h, input int m, input int s);
    logic [5:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    bus.upd = u;
    bus.hh  = 5'(h);
    bus.mm  = 6'(m);
    bus.ss  = 6'(s);
    model_out(k, an_e, seg_e, dp_e);
    if (u) begin
      m_hh  = h;
      m_mm  = m;
      m_ss  = s;
      m_err = (h > 23) || (m > 59) || (s > 59);
    end
    @(posedge clk);
    #1;
    k++;
    check("an",  32'(bus.an),  32'(an_e));
    check("seg", 32'(bus.seg), 32'(seg_e));
    check("dp",  32'(bus.dp),  32'(dp_e));
    check("err", 32'(bus.err), 32'(m_err));
    bus.upd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
  endtask

  task automatic model_reset();
    k = 0;
    m_hh = 0;
    m_mm = 0;
    m_ss = 0;
    m_err = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.upd = 1'b1;
    bus.hh  = 5'd12;
    bus.mm  = 6'd34;
    bus.ss  = 6'd56;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_an",  32'(bus.an),  32'h3F);
      check("rst_seg", 32'(bus.seg), 32'h7F);
      check("rst_dp",  32'(bus.dp),  32'h1);
      check("rst_err", 32'(bus.err), 32'h0);
    end
    bus.upd = 1'b0;
    rst_n = 1'b1;

    idle(2 * SCAN_DIV);
    step(1'b1, 12, 34, 56);
    idle(6 * SCAN_DIV);
    step(1'b1, 7, 5, 9);
    idle(6 * SCAN_DIV);
    step(1'b1, 24, 0, 0);
    idle(6 * SCAN_DIV);
    step(1'b1, 23, 59, 59);
    idle(6 * SCAN_DIV);
    step(1'b1, 12, 34, 57);
    idle(6 * SCAN_DIV);

    // Snapshot update on the exact edge the scan moves from digit 1 to digit 2.
    for (int i = 0; i < 100; i++) begin
      if (((k + 1) % SCAN_DIV == 0) && (((k + 1) / SCAN_DIV) % 6 == 2)) break;
      step(1'b0, 0, 0, 0);
    end
    step(1'b1, 10, 47, 20);
    idle(SCAN_DIV);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        step(1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 63)));
      else if ($urandom_range(0, 5) == 0)
        step(1'b1, int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
             int'($urandom_range(0, 59)));
      else
        step(1'b0, 0, 0, 0);
    end

    step(1'b1, 21, 8, 33);
    for (int i = 0; i < 20; i++) begin
      if (k % SCAN_DIV == 5) break;
      step(1'b0, 0, 0, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an",  32'(bus.an),  32'h3F);
    check("async_seg", 32'(bus.seg), 32'h7F);
    check("async_dp",  32'(bus.dp),  32'h1);
    check("async_err", 32'(bus.err), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(3 * SCAN_DIV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
